// File: rtl/instr_issue.sv
// instr_issue: fetch/wait/issue sequencer between instruction memory and the control decoder.
// Optional handshake counter output issue_cnt is enabled by defining ISSUE_CNT_EN.
module instr_issue #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          OPC_MSB  = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [15:0] issue_instr,
  output logic [2:0]  issue_opcode,
  output logic [15:0] issue_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target
`ifdef ISSUE_CNT_EN
  ,
  output logic [15:0] issue_cnt
`endif
);
  typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;
  state_t state, nxt;
  logic [15:0] pc;
  logic hs;
  assign hs = issue_valid & issue_ready;
  always_ff @(posedge clk)
    state <= rst ? FETCH : nxt;
  // a redirect from any state restarts fetching, dropping any in-flight read
  always_comb
    nxt = redirect_valid ? FETCH :
          state == FETCH ? WAIT  :
          state == WAIT  ? ISSUE :
          hs             ? FETCH : ISSUE;
  always_comb begin
    imem_rd_en   = (state == FETCH) & ~rst;
    imem_addr    = pc;
    issue_opcode = issue_instr[OPC_MSB -: 3];
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc          <= RESET_PC;
      issue_valid <= 1'b0;
      issue_instr <= '0;
      issue_pc    <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_target;
      issue_valid <= 1'b0;
    end else if (state == WAIT) begin
      issue_instr <= imem_rdata;
      issue_pc    <= pc;
      issue_valid <= 1'b1;
    end else if (hs) begin
      pc          <= pc + 16'd1;
      issue_valid <= 1'b0;
    end
`ifdef ISSUE_CNT_EN
  always_ff @(posedge clk)
    if (rst) issue_cnt <= '0;
    else if (hs) issue_cnt <= issue_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: directed check of instr_issue against a fetch-age model, plus a RESET_PC=FFFF wrap instance.
module tb_instr_issue;
  logic clk = 1'b0;
  logic rst, imem_rd_en, issue_valid, issue_ready, redirect_valid;
  logic [15:0] imem_addr, imem_rdata, issue_instr, issue_pc, redirect_target;
  logic [2:0] issue_opcode;
  logic rd2, valid2;
  logic [15:0] addr2, instr2, pc2;
  logic [2:0] opc2;
`ifdef ISSUE_CNT_EN
  logic [15:0] issue_cnt, cnt2;
`endif
  int errors = 0, checks = 0;
  logic [15:0] m_pc, m_instr, m_ipc, m_cnt, last_addr, snap;
  int m_age;
  logic last_rd;
  logic [15:0] q2[$];

  always #5 clk = ~clk;

  instr_issue dut (
    .clk(clk), .rst(rst), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_opcode(issue_opcode), .issue_pc(issue_pc), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target)
`ifdef ISSUE_CNT_EN
    , .issue_cnt(issue_cnt)
`endif
  );

  instr_issue #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst), .imem_rd_en(rd2), .imem_addr(addr2), .imem_rdata(16'h4000),
    .issue_valid(valid2), .issue_ready(1'b1), .issue_instr(instr2),
    .issue_opcode(opc2), .issue_pc(pc2), .redirect_valid(1'b0),
    .redirect_target(16'h0000)
`ifdef ISSUE_CNT_EN
    , .issue_cnt(cnt2)
`endif
  );

  function automatic logic [15:0] memval(input logic [15:0] a);
    return a * 16'h0123 + 16'h2000;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [15:0] tgt);
    logic hs;
    logic [15:0] opc;
    imem_rdata = last_rd ? memval(last_addr) : 16'hBEEF;
    rst = r; issue_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    #1;
    opc = {13'd0, m_instr[15:13]};
    chk("rd_en", {15'd0, imem_rd_en}, {15'd0, !r && m_age == 0});
    if (!r && m_age == 0) chk("addr", imem_addr, m_pc);
    chk("valid", {15'd0, issue_valid}, {15'd0, m_age == 2});
    chk("instr", issue_instr, m_instr);
    chk("ipc", issue_pc, m_ipc);
    chk("opcode", {13'd0, issue_opcode}, opc);
`ifdef ISSUE_CNT_EN
    chk("cnt", issue_cnt, m_cnt);
`endif
    last_rd = imem_rd_en; last_addr = imem_addr;
    if (rd2) q2.push_back(addr2);
    hs = !r && m_age == 2 && rdy;
    @(posedge clk);
    if (r) begin
      m_pc = 16'h0000; m_age = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
    end else begin
      if (hs) m_cnt = m_cnt + 1;
      if (rv) begin
        m_pc = tgt; m_age = 0;
      end else if (m_age == 1) begin
        m_instr = memval(m_pc); m_ipc = m_pc; m_age = 2;
      end else if (m_age == 0) m_age = 1;
      else if (hs) begin
        m_pc = m_pc + 1; m_age = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; issue_ready = 0; redirect_valid = 0; redirect_target = 0; imem_rdata = 0;
    last_rd = 0; last_addr = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_cnt = 0; m_age = 0;
    @(negedge clk);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    // first fetch after reset release, immediate acceptance
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    chk("lit_valid", {15'd0, issue_valid}, 16'd1);
    chk("lit_opc001", {13'd0, issue_opcode}, 16'd1);
    chk("lit_instr", issue_instr, 16'h2000);
    chk("lit_ipc0", issue_pc, 16'h0000);
    step(0, 1, 0, 0);
    chk("lit_next_addr1", imem_addr, 16'h0001);
    chk("lit_next_rd", {15'd0, imem_rd_en}, 16'd1);
    // stall: held instruction stays stable
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    snap = issue_instr;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("lit_stall_instr", issue_instr, snap);
    chk("lit_stall_ipc", issue_pc, 16'h0001);
    step(0, 1, 0, 0);
    chk("lit_after_hs", imem_addr, 16'h0002);
    // redirect during WAIT drops the read
    step(0, 0, 0, 0); step(0, 0, 1, 16'h0040);
    chk("lit_wait_redir_valid", {15'd0, issue_valid}, 16'd0);
    chk("lit_wait_redir_addr", imem_addr, 16'h0040);
    // redirect during FETCH
    step(0, 0, 1, 16'h0080);
    chk("lit_fetch_redir", imem_addr, 16'h0080);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("lit_instr80", issue_instr, memval(16'h0080));
    // handshake and redirect together
    step(0, 1, 1, 16'h0010);
    chk("lit_hs_redir_addr", imem_addr, 16'h0010);
    chk("lit_hs_redir_valid", {15'd0, issue_valid}, 16'd0);
`ifdef ISSUE_CNT_EN
    chk("lit_cnt3", issue_cnt, 16'd3);
`endif
    // redirect while holding without ready
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 1, 16'hFFFF);
    // PC wrap FFFF -> 0000
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    chk("lit_wrap", imem_addr, 16'h0000);
    // reset while holding an instruction
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("lit_rst_valid", {15'd0, issue_valid}, 16'd0);
    chk("lit_rst_instr", issue_instr, 16'h0000);
    step(0, 0, 0, 0);
    chk("lit_rst_restart", {15'd0, m_age == 1 ? 1'b1 : 1'b0}, 16'd1);
    for (int i = 0; i < 60; i++)
      step(0, 1'($urandom % 2), ($urandom % 8) == 0, 16'($urandom));
    chk("wrap2_first", q2.size() > 1 ? q2[0] : 16'h1234, 16'hFFFF);
    chk("wrap2_second", q2.size() > 1 ? q2[1] : 16'h1234, 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
